// File: rtl/imem_fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, drives word reads from a
// combinational-read instruction memory, buffers fetched words in a small
// prefetch FIFO and presents {pc, instr} to decode with a valid/ready handshake.
// Waits a few cycles after reset for the memory image to settle, flushes on
// redirect and halts (sticky fault) when the PC leaves the memory range.
module imem_fetch_sequencer #(
    parameter int WIDTH       = 32,
    parameter int RESET_PC    = 0,
    parameter int IMEM_LEN    = 72,
    parameter int FIFO_DEPTH  = 4,
    parameter int BOOT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-3:0] imem_addr,
    input  logic [WIDTH-1:0] imem_data,
    input  logic             fetch_en,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [WIDTH-1:0] inst_data,
    output logic [WIDTH-1:0] inst_pc,
    output logic             fetch_fault
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BOOT_W = $clog2(BOOT_CYCLES) + 1;

    localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   pc_q, pc_d;
    logic [BOOT_W-1:0]  boot_cnt_q, boot_cnt_d;
    logic               fault_q, fault_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // Prefetch storage: PC and instruction word per entry
    logic [WIDTH-1:0]   fifo_pc   [FIFO_DEPTH];
    logic [WIDTH-1:0]   fifo_data [FIFO_DEPTH];

    logic               push;
    logic               pop;
    logic               in_range;
    logic [WIDTH:0]     pc_end;

    // The two low bits of a redirect target are discarded by design
    logic               unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // One bit wider than the PC so a PC near the top of the address space
    // cannot wrap around and look in range
    assign pc_end   = {1'b0, pc_q} + (WIDTH+1)'(4);
    assign in_range = (pc_end <= (WIDTH+1)'(IMEM_LEN));

    assign imem_addr   = pc_q[WIDTH-1:2];
    assign inst_valid  = (count_q != '0);
    assign inst_data   = inst_valid ? fifo_data[rd_ptr_q] : '0;
    assign inst_pc     = inst_valid ? fifo_pc[rd_ptr_q]   : '0;
    assign fetch_fault = fault_q;
    assign pop         = inst_valid & inst_ready;

    // Next-state: redirect flushes and wins over everything; otherwise sequence boot, fetch and halt
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        boot_cnt_d = boot_cnt_q;
        fault_d    = fault_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        push       = 1'b0;

        if (redirect_valid) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            pc_d     = {redirect_pc[WIDTH-1:2], 2'b00};
            fault_d  = 1'b0;
            if (state_q == ST_BOOT) begin
                // Keep counting the settle time but never leave boot on a redirect edge
                if (boot_cnt_q != BOOT_LAST) begin
                    boot_cnt_d = boot_cnt_q + BOOT_W'(1);
                end
            end else begin
                state_d = ST_FETCH;
            end
        end else begin
            case (state_q)
                ST_BOOT: begin
                    if (boot_cnt_q == BOOT_LAST) begin
                        state_d = ST_FETCH;
                    end else begin
                        boot_cnt_d = boot_cnt_q + BOOT_W'(1);
                    end
                end
                ST_FETCH: begin
                    if (fetch_en) begin
                        if (in_range) begin
                            // A full FIFO still accepts when the head leaves this cycle
                            push = (count_q < CNT_FULL) | pop;
                        end else begin
                            fault_d = 1'b1;
                            state_d = ST_HALT;
                        end
                    end
                end
                default: begin
                    // Halted: no fetches, the FIFO keeps draining
                end
            endcase

            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                pc_d     = pc_q + WIDTH'(4);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Control and pointer registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            pc_q       <= WIDTH'(RESET_PC);
            boot_cnt_q <= '0;
            fault_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            boot_cnt_q <= boot_cnt_d;
            fault_q    <= fault_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // FIFO entry writes; contents need no reset because the count gates visibility
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (!rst && push && (wr_ptr_q == PTR_W'(gi))) begin
                    fifo_pc[gi]   <= pc_q;
                    fifo_data[gi] <= imem_data;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Testbench for imem_fetch_sequencer: a byte-array instruction memory, a
// queue-based reference model of the fetch stream, directed scenarios and a
// randomized run.
module tb_imem_fetch_sequencer;

    localparam int LEN   = 72;
    localparam int DEPTH = 4;
    localparam int BOOT  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] imem_addr;
    logic [31:0] imem_data;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        fetch_fault;

    int checks   = 0;
    int failures = 0;

    byte unsigned mem [LEN];

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_q [$];
    int          m_boot;
    bit          m_halt;
    bit          m_fault;

    always #5 clk = ~clk;

    imem_fetch_sequencer #(
        .WIDTH(32), .RESET_PC(0), .IMEM_LEN(LEN), .FIFO_DEPTH(DEPTH), .BOOT_CYCLES(BOOT)
    ) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
        .fetch_en(fetch_en), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
        .inst_pc(inst_pc), .fetch_fault(fetch_fault)
    );

    // Big-endian word at a byte address; a recognisable pattern outside the image
    function automatic logic [31:0] word_at(logic [31:0] a);
        if (longint'(a) + 4 <= LEN)
            return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
        return 32'hDEADBEEF;
    endfunction

    assign imem_data = word_at({imem_addr, 2'b00});

    wire [95:0] obs_vec = {inst_valid, inst_pc, inst_data, imem_addr, fetch_fault};

    function automatic logic [95:0] exp_vec();
        logic [31:0] hp;
        if (m_q.size() == 0)
            return {1'b0, 32'h0, 32'h0, m_pc[31:2], m_fault};
        hp = m_q[0];
        return {1'b1, hp, word_at(hp), m_pc[31:2], m_fault};
    endfunction

    // Advance the reference model by one clock using the inputs currently driven
    task automatic model_step();
        bit pop, full;
        pop  = (m_q.size() != 0) && inst_ready;
        full = (m_q.size() >= DEPTH);
        if (rst) begin
            m_pc = 32'h0; m_q.delete(); m_boot = BOOT; m_halt = 0; m_fault = 0;
        end else if (redirect_valid) begin
            m_q.delete();
            m_pc    = redirect_pc & ~32'h3;
            m_fault = 0;
            m_halt  = 0;
            if (m_boot > 1) m_boot--;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (m_boot > 0) begin
                m_boot--;
            end else if (!m_halt && fetch_en) begin
                if (longint'(m_pc) + 4 <= LEN) begin
                    if (!full || pop) begin
                        m_q.push_back(m_pc);
                        m_pc = m_pc + 32'd4;
                    end
                end else begin
                    m_fault = 1;
                    m_halt  = 1;
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        fetch_en = 1'b1; inst_ready = 1'b1;
        do_reset();
        checks++;
        if (obs_vec !== {1'b0, 32'h0, 32'h0, 30'h0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state got=%h want=%h", obs_vec, {1'b0, 32'h0, 32'h0, 30'h0, 1'b0});
        end
        $display("test_reset: outputs=%h", obs_vec);
    endtask

    task automatic test_boot_stream();
        int first = -1;
        fetch_en = 1'b1; inst_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (obs_vec !== exp_vec()) begin
                failures++;
                $display("FAIL boot_stream cyc=%0d got=%h want=%h", i, obs_vec, exp_vec());
            end
            if (inst_valid === 1'b1 && first < 0) first = i;
            tick();
        end
        checks++;
        if (first !== 3) begin
            failures++;
            $display("FAIL boot_latency got=%0d want=3", first);
        end
        $display("test_boot_stream: first valid at cycle %0d", first);
    endtask

    task automatic test_backpressure();
        fetch_en = 1'b1; inst_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (obs_vec !== exp_vec()) begin
                failures++;
                $display("FAIL backpressure_fill cyc=%0d got=%h want=%h", i, obs_vec, exp_vec());
            end
            tick();
        end
        checks++;
        if (imem_addr !== 30'h4) begin
            failures++;
            $display("FAIL backpressure_addr got=%h want=4", imem_addr);
        end
        inst_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (!(inst_valid === 1'b1 && inst_pc === 32'(k * 4) && obs_vec === exp_vec())) begin
                failures++;
                $display("FAIL backpressure_drain k=%0d got=%h want=%h", k, obs_vec, exp_vec());
            end
            tick();
        end
        $display("test_backpressure: drained to pc 0x10 in order");
    endtask

    task automatic test_redirect();
        int guard = 0;
        fetch_en = 1'b1; inst_ready = 1'b0;
        do_reset();
        while (m_q.size() < 3 && guard < 20) begin
            checks++;
            if (obs_vec !== exp_vec()) begin
                failures++;
                $display("FAIL redirect_fill cyc=%0d got=%h want=%h", guard, obs_vec, exp_vec());
            end
            tick();
            guard++;
        end
        redirect_valid = 1'b1; redirect_pc = 32'h23;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || obs_vec !== exp_vec()) begin
            failures++;
            $display("FAIL redirect_flush got=%h want=%h", obs_vec, exp_vec());
        end
        tick();
        checks++;
        if (!(inst_valid === 1'b1 && inst_pc === 32'h20) || obs_vec !== exp_vec()) begin
            failures++;
            $display("FAIL redirect_target got=%h want=%h", obs_vec, exp_vec());
        end
        tick();
        $display("test_redirect: restarted at 0x20");
    endtask

    task automatic test_range_fault();
        int          cyc = 0;
        logic [31:0] last_seen = 32'hFFFFFFFF;
        fetch_en = 1'b1; inst_ready = 1'b1;
        do_reset();
        while (fetch_fault !== 1'b1 && cyc < 60) begin
            checks++;
            if (obs_vec !== exp_vec()) begin
                failures++;
                $display("FAIL fault_run cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec());
            end
            if (inst_valid === 1'b1) last_seen = inst_pc;
            tick();
            cyc++;
        end
        checks++;
        if (fetch_fault !== 1'b1 || imem_addr !== 30'h12) begin
            failures++;
            $display("FAIL fault_raise got fault=%b addr=%h want fault=1 addr=12", fetch_fault, imem_addr);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs_vec !== exp_vec()) begin
                failures++;
                $display("FAIL fault_halt cyc=%0d got=%h want=%h", i, obs_vec, exp_vec());
            end
            if (inst_valid === 1'b1) last_seen = inst_pc;
            tick();
        end
        checks++;
        if (last_seen !== 32'h44) begin
            failures++;
            $display("FAIL fault_last_pc got=%h want=44", last_seen);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (fetch_fault !== 1'b0 || obs_vec !== exp_vec()) begin
            failures++;
            $display("FAIL fault_clear got=%h want=%h", obs_vec, exp_vec());
        end
        tick();
        checks++;
        if (!(inst_valid === 1'b1 && inst_pc === 32'h0) || obs_vec !== exp_vec()) begin
            failures++;
            $display("FAIL fault_resume got=%h want=%h", obs_vec, exp_vec());
        end
        $display("test_range_fault: halted after 0x44, resumed at 0x00");
    endtask

    task automatic test_reset_midrun();
        int first = -1;
        fetch_en = 1'b1; inst_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (inst_valid !== 1'b1 || obs_vec !== exp_vec()) begin
            failures++;
            $display("FAIL midrun_full got=%h want=%h", obs_vec, exp_vec());
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || imem_addr !== 30'h0) begin
            failures++;
            $display("FAIL midrun_reset got valid=%b addr=%h want valid=0 addr=0", inst_valid, imem_addr);
        end
        inst_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs_vec !== exp_vec()) begin
                failures++;
                $display("FAIL midrun_reboot cyc=%0d got=%h want=%h", i, obs_vec, exp_vec());
            end
            if (inst_valid === 1'b1 && first < 0) first = i;
            tick();
        end
        checks++;
        if (first !== 3) begin
            failures++;
            $display("FAIL midrun_boot_latency got=%0d want=3", first);
        end
        $display("test_reset_midrun: reboot first valid at cycle %0d", first);
    endtask

    task automatic test_fetch_en_toggle();
        logic [31:0] next_pc = 32'h0;
        inst_ready = 1'b1; fetch_en = 1'b1;
        do_reset();
        for (int i = 0; i < 24; i++) begin
            fetch_en = i[0];
            checks++;
            if (obs_vec !== exp_vec()) begin
                failures++;
                $display("FAIL toggle cyc=%0d got=%h want=%h", i, obs_vec, exp_vec());
            end
            if (inst_valid === 1'b1) begin
                checks++;
                if (inst_pc !== next_pc) begin
                    failures++;
                    $display("FAIL toggle_order got=%h want=%h", inst_pc, next_pc);
                end
                next_pc = next_pc + 32'd4;
            end
            tick();
        end
        $display("test_fetch_en_toggle: delivered up to pc %h", next_pc);
    endtask

    task automatic test_random();
        int bad = 0;
        fetch_en = 1'b1; inst_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            fetch_en       = ($urandom_range(0, 3) != 0);
            inst_ready     = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 24) == 0);
            redirect_pc    = 32'($urandom_range(0, 90));
            checks++;
            if (obs_vec !== exp_vec()) begin
                failures++;
                bad++;
                $display("FAIL random cyc=%0d got=%h want=%h", i, obs_vec, exp_vec());
            end
            tick();
        end
        redirect_valid = 1'b0;
        $display("test_random: 400 cycles, %0d mismatching", bad);
    endtask

    initial begin
        rst = 1'b1; fetch_en = 1'b0; inst_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        m_pc = 32'h0; m_boot = BOOT; m_halt = 0; m_fault = 0;
        for (int i = 0; i < LEN; i++) mem[i] = 8'($urandom);
        test_reset();
        test_boot_stream();
        test_backpressure();
        test_redirect();
        test_range_fault();
        test_reset_midrun();
        test_fetch_en_toggle();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
